recv_inference: RTL and testbench
=================================

RECV_INFERENCE -- requirements
Module: recv_inference

Interface
REQ-001 The block SHALL expose parameter BEAT_BYTES, default 64, meaning the bytes per 512-bit data beat.
REQ-002 The block SHALL expose parameter ACK_LEN, default 64, meaning the byte length of the acknowledge message sent over TCP.
REQ-003 The block SHALL expose port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL expose port rstn, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL expose port axis_dma_write_cmd, axis_mem_cmd.master: DMA write command (valid, ready, address[63:0], length[31:0]).
REQ-006 The block SHALL expose port axis_dma_write_data, axi_stream.master: DMA write payload (data[511:0], keep[63:0], last).
REQ-007 The block SHALL expose port s_axis_rx_metadata, axis_meta.slave: TCP receive metadata, with data[15:0] = session id.
REQ-008 The block SHALL expose port s_axis_rx_data, axi_stream.slave: TCP receive payload, 512 bits wide.
REQ-009 The block SHALL expose port m_axis_tx_metadata, axis_meta.master: TCP send metadata, with data = {length[31:0], session[15:0]}.
REQ-010 The block SHALL expose port m_axis_tx_data, axi_stream.master: TCP send payload (the acknowledge message).
REQ-011 The block SHALL expose port control_reg, input [14:0][31:0], laid out as follows:
- [1] = address low
- [2] = address high
- [3][0] = arm
- [4] = transfer length in bytes
REQ-012 The block SHALL expose port status_reg, output [7:0][31:0]: the counters defined in REQ-024.

Function
REQ-013 The block SHALL register control_reg fields every cycle, and SHALL detect an arm event as the rising edge of the registered control_reg[3][0].
REQ-014 The FSM SHALL have states IDLE, CMD, DATA, ACK_META and ACK_DATA; reset and default state is IDLE.
REQ-015 IDLE SHALL transition to CMD on an arm event; when not in IDLE, an arm event SHALL be ignored.
REQ-016 On entering CMD, the block SHALL latch length and base address, and SHALL compute beat_total = length>>6 (32-bit); the length SHALL be taken as a nonzero multiple of 64.
REQ-017 In CMD, the block SHALL assert axis_dma_write_cmd.valid with the latched address and length, and SHALL go to DATA on the cycle valid&ready is true.
REQ-018 In DATA, the rx payload SHALL pass through combinationally:
- s_axis_rx_data.ready = axis_dma_write_data.ready
- axis_dma_write_data.valid = s_axis_rx_data.valid
- data and keep pass through unchanged.
REQ-019 In DATA, the block SHALL count each accepted beat in beat_cnt.
- last SHALL be driven by the block as (beat_cnt == beat_total-1); the incoming rx last SHALL be ignored.
- The beat transferred with last SHALL end DATA and clear beat_cnt to 0.
REQ-020 Outside DATA, s_axis_rx_data.ready and axis_dma_write_data.valid SHALL be 0, so that extra rx data is backpressured and not dropped.
REQ-021 s_axis_rx_metadata.ready SHALL be constantly 1, and data[15:0] SHALL be latched as session_id on every valid beat.
REQ-022 ACK_META SHALL assert m_axis_tx_metadata.valid with data {ACK_LEN, session_id}, and SHALL go to ACK_DATA on handshake.
REQ-023 ACK_DATA SHALL send exactly one beat, then return to IDLE on handshake:
- data[31:0] = beats received
- data[63:32] = latency counter
- all other data bits 0
- keep all-ones
- last=1
REQ-024 Status SHALL be reported as follows:
- status_reg[0] = latency counter: cleared on arm, counts every cycle from the first accepted DATA beat up to and including the last beat.
- status_reg[1] = completed transfers, wrapping at 2^32.
- status_reg[2] = beats received in the current or last transfer.
- status_reg[3][2:0] = FSM state encoding.
- status_reg[7:4] = 0.
REQ-025 When the DMA command handshake and an rx beat coincide, the rx beat SHALL NOT be accepted until the cycle after entering DATA.

Reset
REQ-026 While rstn=0 at a clk edge, the FSM SHALL go to IDLE, all counters and session_id SHALL clear, and all master valid outputs SHALL be 0 in the following cycle.
REQ-027 A reset during any state SHALL abandon the transfer without emitting last or an acknowledge; a partially written DMA transfer is not completed.

Configuration
REQ-028 With macro RECV_INFERENCE_ACK_EN defined, the block SHALL implement the ACK_META and ACK_DATA states as specified.
REQ-029 Without RECV_INFERENCE_ACK_EN, DATA SHALL return directly to IDLE after the last beat, and m_axis_tx_metadata.valid and m_axis_tx_data.valid SHALL be tied 0.

Verification
REQ-030 Scenario: length=0x26400, address=0x1_0000_0000, arm; feed 2448 beats with ready always 1 -> one DMA command with those values, last on beat 2448 only, status_reg[1]=1, status_reg[2]=2448.
REQ-031 Scenario: rx metadata session 0x0005 and the REQ-030 transfer, with the ACK macro defined -> tx metadata {0x40,0x0005}, then one tx beat with data[31:0]=2448 and last=1.
REQ-032 Scenario: length=64, DMA write ready toggling 1/0 -> a single beat with last=1, s_axis_rx_data.ready mirrors the DMA ready, and no beat is lost or duplicated.
REQ-033 Scenario: rx data valid while IDLE, then arm -> no beats accepted before DATA, and beats are delivered in order afterward.
REQ-034 Scenario: second arm edge mid-DATA -> ignored, and exactly one DMA command is issued.
REQ-035 Scenario: rstn=0 in DATA after 10 beats -> next cycle state is IDLE, all valid outputs are 0, and status_reg[2]=0.

Source files
------------

// File: rtl/recv_inference.sv
// rtl/recv_inference.sv - TCP receive payload to DMA write bridge, optional acknowledge (RECV_INFERENCE_ACK_EN)
module recv_inference #(
    parameter int BEAT_BYTES = 64,
    parameter int ACK_LEN    = 64
) (
    input  logic                      clk,
    input  logic                      rstn,
    output logic                      axis_dma_write_cmd_valid_o,
    input  logic                      axis_dma_write_cmd_ready_i,
    output logic [63:0]               axis_dma_write_cmd_address_o,
    output logic [31:0]               axis_dma_write_cmd_length_o,
    output logic [BEAT_BYTES*8-1:0]   axis_dma_write_data_tdata_o,
    output logic [BEAT_BYTES-1:0]     axis_dma_write_data_tkeep_o,
    output logic                      axis_dma_write_data_tlast_o,
    output logic                      axis_dma_write_data_tvalid_o,
    input  logic                      axis_dma_write_data_tready_i,
    input  logic                      s_axis_rx_metadata_tvalid_i,
    output logic                      s_axis_rx_metadata_tready_o,
    input  logic [15:0]               s_axis_rx_metadata_tdata_i,
    input  logic [BEAT_BYTES*8-1:0]   s_axis_rx_data_tdata_i,
    input  logic [BEAT_BYTES-1:0]     s_axis_rx_data_tkeep_i,
    input  logic                      s_axis_rx_data_tlast_i,
    input  logic                      s_axis_rx_data_tvalid_i,
    output logic                      s_axis_rx_data_tready_o,
    output logic                      m_axis_tx_metadata_tvalid_o,
    input  logic                      m_axis_tx_metadata_tready_i,
    output logic [47:0]               m_axis_tx_metadata_tdata_o,
    output logic [BEAT_BYTES*8-1:0]   m_axis_tx_data_tdata_o,
    output logic [BEAT_BYTES-1:0]     m_axis_tx_data_tkeep_o,
    output logic                      m_axis_tx_data_tlast_o,
    output logic                      m_axis_tx_data_tvalid_o,
    input  logic                      m_axis_tx_data_tready_i,
    input  logic [14:0][31:0]         control_reg_i,
    output logic [7:0][31:0]          status_reg_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_DATA     = 3'd2,
        ST_ACK_META = 3'd3,
        ST_ACK_DATA = 3'd4
    } state_t;

    localparam logic [31:0] ACK_LEN_W = 32'(ACK_LEN);

    state_t      state_q, state_d;
    logic        arm_q, arm_prev_q;
    logic [63:0] addr_q, cmd_addr_q;
    logic [31:0] len_q, cmd_len_q;
    logic [31:0] beat_total_q, beat_cnt_q, rx_beats_q, lat_q, done_q;
    logic [15:0] session_q;

    logic in_data, dma_fire, last_beat, arm_evt, tx_meta_fire, tx_data_fire;

    // The rx tlast and unused control words carry nothing for this block.
    logic unused_inputs;
    assign unused_inputs = ^{control_reg_i[0], control_reg_i[14:5],
                             control_reg_i[3][31:1], s_axis_rx_data_tlast_i};

    assign in_data      = (state_q == ST_DATA);
    assign dma_fire     = in_data & s_axis_rx_data_tvalid_i & axis_dma_write_data_tready_i;
    assign last_beat    = (beat_cnt_q == beat_total_q - 32'd1);
    assign arm_evt      = arm_q & ~arm_prev_q;
    assign tx_meta_fire = m_axis_tx_metadata_tvalid_o & m_axis_tx_metadata_tready_i;
    assign tx_data_fire = m_axis_tx_data_tvalid_o & m_axis_tx_data_tready_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (arm_evt) state_d = ST_CMD;
            ST_CMD:      if (axis_dma_write_cmd_ready_i) state_d = ST_DATA;
            ST_DATA: begin
                if (dma_fire && last_beat) begin
`ifdef RECV_INFERENCE_ACK_EN
                    state_d = ST_ACK_META;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_ACK_META: if (tx_meta_fire) state_d = ST_ACK_DATA;
            ST_ACK_DATA: if (tx_data_fire) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            arm_q        <= 1'b0;
            arm_prev_q   <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            beat_total_q <= '0;
            beat_cnt_q   <= '0;
            rx_beats_q   <= '0;
            lat_q        <= '0;
            done_q       <= '0;
            session_q    <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= control_reg_i[3][0];
            arm_prev_q <= arm_q;
            addr_q     <= {control_reg_i[2], control_reg_i[1]};
            len_q      <= control_reg_i[4];
            if (s_axis_rx_metadata_tvalid_i)
                session_q <= s_axis_rx_metadata_tdata_i;
            if (state_q == ST_IDLE && arm_evt) begin
                cmd_addr_q   <= addr_q;
                cmd_len_q    <= len_q;
                beat_total_q <= len_q >> 6;
                beat_cnt_q   <= '0;
                rx_beats_q   <= '0;
                lat_q        <= '0;
            end
            // Latency runs from the first accepted beat through the last one.
            if (in_data && (dma_fire || rx_beats_q != 32'd0))
                lat_q <= lat_q + 32'd1;
            if (dma_fire) begin
                rx_beats_q <= rx_beats_q + 32'd1;
                if (last_beat) begin
                    beat_cnt_q <= '0;
                    done_q     <= done_q + 32'd1;
                end else begin
                    beat_cnt_q <= beat_cnt_q + 32'd1;
                end
            end
        end
    end

    assign axis_dma_write_cmd_valid_o   = (state_q == ST_CMD);
    assign axis_dma_write_cmd_address_o = cmd_addr_q;
    assign axis_dma_write_cmd_length_o  = cmd_len_q;

    assign axis_dma_write_data_tdata_o  = s_axis_rx_data_tdata_i;
    assign axis_dma_write_data_tkeep_o  = s_axis_rx_data_tkeep_i;
    assign axis_dma_write_data_tvalid_o = in_data & s_axis_rx_data_tvalid_i;
    assign axis_dma_write_data_tlast_o  = in_data & last_beat;
    assign s_axis_rx_data_tready_o      = in_data & axis_dma_write_data_tready_i;
    assign s_axis_rx_metadata_tready_o  = 1'b1;

    assign m_axis_tx_metadata_tdata_o = {ACK_LEN_W, session_q};
    assign m_axis_tx_data_tdata_o     = {{(BEAT_BYTES*8-64){1'b0}}, lat_q, rx_beats_q};
    assign m_axis_tx_data_tkeep_o     = '1;
    assign m_axis_tx_data_tlast_o     = 1'b1;
`ifdef RECV_INFERENCE_ACK_EN
    assign m_axis_tx_metadata_tvalid_o = (state_q == ST_ACK_META);
    assign m_axis_tx_data_tvalid_o     = (state_q == ST_ACK_DATA);
`else
    assign m_axis_tx_metadata_tvalid_o = 1'b0;
    assign m_axis_tx_data_tvalid_o     = 1'b0;
`endif

    always_comb begin
        status_reg_o       = '0;
        status_reg_o[0]    = lat_q;
        status_reg_o[1]    = done_q;
        status_reg_o[2]    = rx_beats_q;
        status_reg_o[3]    = {29'd0, state_q};
    end

endmodule

// File: tb/tb_recv_inference.sv
// tb/tb_recv_inference.sv - directed bench for recv_inference (ACK checks under RECV_INFERENCE_ACK_EN)
module tb_recv_inference;

    localparam int BB = 64;
    localparam int DW = BB * 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic              cmd_valid, cmd_ready;
    logic [63:0]       cmd_addr;
    logic [31:0]       cmd_len;
    logic [DW-1:0]     dma_tdata;
    logic [BB-1:0]     dma_tkeep;
    logic              dma_tlast, dma_tvalid, dma_tready;
    logic              meta_tvalid, meta_tready;
    logic [15:0]       meta_tdata;
    logic [DW-1:0]     rx_tdata;
    logic [BB-1:0]     rx_tkeep;
    logic              rx_tlast, rx_tvalid, rx_tready;
    logic              txm_tvalid, txm_tready;
    logic [47:0]       txm_tdata;
    logic [DW-1:0]     txd_tdata;
    logic [BB-1:0]     txd_tkeep;
    logic              txd_tlast, txd_tvalid, txd_tready;
    logic [14:0][31:0] ctrl;
    logic [7:0][31:0]  status;

    recv_inference #(.BEAT_BYTES(BB), .ACK_LEN(64)) dut (
        .clk(clk), .rstn(rstn),
        .axis_dma_write_cmd_valid_o(cmd_valid), .axis_dma_write_cmd_ready_i(cmd_ready),
        .axis_dma_write_cmd_address_o(cmd_addr), .axis_dma_write_cmd_length_o(cmd_len),
        .axis_dma_write_data_tdata_o(dma_tdata), .axis_dma_write_data_tkeep_o(dma_tkeep),
        .axis_dma_write_data_tlast_o(dma_tlast), .axis_dma_write_data_tvalid_o(dma_tvalid),
        .axis_dma_write_data_tready_i(dma_tready),
        .s_axis_rx_metadata_tvalid_i(meta_tvalid), .s_axis_rx_metadata_tready_o(meta_tready),
        .s_axis_rx_metadata_tdata_i(meta_tdata),
        .s_axis_rx_data_tdata_i(rx_tdata), .s_axis_rx_data_tkeep_i(rx_tkeep),
        .s_axis_rx_data_tlast_i(rx_tlast), .s_axis_rx_data_tvalid_i(rx_tvalid),
        .s_axis_rx_data_tready_o(rx_tready),
        .m_axis_tx_metadata_tvalid_o(txm_tvalid), .m_axis_tx_metadata_tready_i(txm_tready),
        .m_axis_tx_metadata_tdata_o(txm_tdata),
        .m_axis_tx_data_tdata_o(txd_tdata), .m_axis_tx_data_tkeep_o(txd_tkeep),
        .m_axis_tx_data_tlast_o(txd_tlast), .m_axis_tx_data_tvalid_o(txd_tvalid),
        .m_axis_tx_data_tready_i(txd_tready),
        .control_reg_i(ctrl), .status_reg_o(status)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Source: rx beat payload is its sequence number; rx tlast is held high to show it is ignored.
    int   rx_sent  = 0;
    int   rx_limit = 0;
    bit   rx_adv   = 0;
    bit   toggle_mode = 0;
    initial begin
        rx_tdata = '0; rx_tkeep = '1; rx_tlast = 1'b1; rx_tvalid = 1'b0; dma_tready = 1'b1;
    end
    always @(posedge clk) begin
        #1;
        if (rx_adv) rx_sent++;
        rx_tdata   = {{(DW-32){1'b0}}, 32'(rx_sent)};
        rx_tvalid  = (rx_sent < rx_limit);
        dma_tready = toggle_mode ? ~dma_tready : 1'b1;
    end

    int exp_seq = 0, dma_beats = 0, last_cnt = 0, last_at = 0, order_err = 0;
    int cmd_cnt = 0, rx_fires = 0, mirror_err = 0, txm_cnt = 0, txd_cnt = 0;
    logic [63:0] cmd_addr_seen = '0, txd_seen = '0;
    logic [31:0] cmd_len_seen = '0;
    logic [47:0] txm_seen = '0;
    logic        txd_last_seen = 1'b0;

    always @(negedge clk) begin
        rx_adv = rx_tvalid && rx_tready;
        if (rx_adv) rx_fires++;
        if (rx_tready && !dma_tready) mirror_err++;
        if (cmd_valid && cmd_ready) begin
            cmd_cnt++; cmd_addr_seen = cmd_addr; cmd_len_seen = cmd_len;
        end
        if (dma_tvalid && dma_tready) begin
            if (dma_tdata[31:0] != 32'(exp_seq)) order_err++;
            exp_seq++;
            dma_beats++;
            if (dma_tlast) begin last_cnt++; last_at = dma_beats; end
        end
        if (txm_tvalid && txm_tready) begin txm_cnt++; txm_seen = txm_tdata; end
        if (txd_tvalid && txd_tready) begin
            txd_cnt++; txd_seen = txd_tdata[63:0]; txd_last_seen = txd_tlast;
        end
    end

    task automatic arm_xfer(input logic [63:0] addr, input logic [31:0] len);
        @(posedge clk); #1;
        ctrl[3][0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ctrl[1] = addr[31:0]; ctrl[2] = addr[63:32]; ctrl[4] = len; ctrl[3][0] = 1'b1;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp_done);
        bit ok = 0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(posedge clk); #2;
            if (status[1] == exp_done && status[3][2:0] == 3'd0) ok = 1;
        end
        chk_eq(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_beats(input string tag, input int target);
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk); #2;
            if (dma_beats >= target) ok = 1;
        end
        chk_eq(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int b_beats, b_last, b_cmd;

    initial begin
        rstn = 1'b0; ctrl = '0; cmd_ready = 1'b1;
        meta_tvalid = 1'b0; meta_tdata = '0; txm_tready = 1'b1; txd_tready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_eq("rst_state", 64'(status[3]), 64'd0);
        chk_eq("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk_eq("rst_rx_tready", 64'(rx_tready), 64'd0);
        chk_eq("rst_meta_tready", 64'(meta_tready), 64'd1);
        chk_eq("rst_done", 64'(status[1]), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Session id, then rx data waiting while IDLE, then a 2448-beat transfer.
        meta_tvalid = 1'b1; meta_tdata = 16'h0005;
        @(posedge clk); #1;
        meta_tvalid = 1'b0; meta_tdata = 16'h00ee;
        rx_limit = 2448;
        repeat (5) @(posedge clk);
        #2;
        chk_eq("idle_no_accept", 64'(rx_fires), 64'd0);
        chk_eq("idle_rx_tready", 64'(rx_tready), 64'd0);
        arm_xfer(64'h1_0000_0000, 32'h26400);
        wait_done("s1_done", 32'd1);
        chk_eq("s1_cmd_cnt", 64'(cmd_cnt), 64'd1);
        chk_eq("s1_cmd_addr", cmd_addr_seen, 64'h1_0000_0000);
        chk_eq("s1_cmd_len", 64'(cmd_len_seen), 64'h26400);
        chk_eq("s1_beats", 64'(dma_beats), 64'd2448);
        chk_eq("s1_last_cnt", 64'(last_cnt), 64'd1);
        chk_eq("s1_last_at", 64'(last_at), 64'd2448);
        chk_eq("s1_order", 64'(order_err), 64'd0);
        chk_eq("s1_status_done", 64'(status[1]), 64'd1);
        chk_eq("s1_status_beats", 64'(status[2]), 64'd2448);
        chk_eq("s1_latency", 64'(status[0]), 64'd2448);
        chk_eq("s1_status_hi", 64'(status[7:4]), 64'd0);
`ifdef RECV_INFERENCE_ACK_EN
        chk_eq("s1_txm_cnt", 64'(txm_cnt), 64'd1);
        chk_eq("s1_txm_data", 64'(txm_seen), 64'h0000_0040_0005);
        chk_eq("s1_txd_cnt", 64'(txd_cnt), 64'd1);
        chk_eq("s1_txd_beats", 64'(txd_seen[31:0]), 64'd2448);
        chk_eq("s1_txd_lat", 64'(txd_seen[63:32]), 64'd2448);
        chk_eq("s1_txd_last", 64'(txd_last_seen), 64'd1);
`else
        chk_eq("s1_txm_none", 64'(txm_cnt), 64'd0);
        chk_eq("s1_txd_none", 64'(txd_cnt), 64'd0);
`endif

        // Single-beat transfer with DMA ready toggling; two extra rx beats stay pending.
        b_beats = dma_beats; b_last = last_cnt;
        toggle_mode = 1;
        rx_limit = rx_sent + 3;
        arm_xfer(64'h2000, 32'd64);
        wait_done("s2_done", 32'd2);
        toggle_mode = 0;
        chk_eq("s2_beats", 64'(dma_beats - b_beats), 64'd1);
        chk_eq("s2_last", 64'(last_cnt - b_last), 64'd1);
        chk_eq("s2_cmd_addr", cmd_addr_seen, 64'h2000);
        chk_eq("s2_status_beats", 64'(status[2]), 64'd1);
        chk_eq("s2_latency", 64'(status[0]), 64'd1);
        chk_eq("s2_mirror", 64'(mirror_err), 64'd0);
        chk_eq("s2_no_loss", 64'(rx_fires), 64'(dma_beats));
        chk_eq("s2_order", 64'(order_err), 64'd0);

        // Second arm edge during DATA is ignored.
        b_beats = dma_beats; b_last = last_cnt; b_cmd = cmd_cnt;
        rx_limit = rx_sent + 20;
        arm_xfer(64'h3000, 32'd1280);
        wait_beats("s3_mid", b_beats + 5);
        #1; ctrl[3][0] = 1'b0;
        repeat (2) @(posedge clk);
        #1; ctrl[3][0] = 1'b1;
        wait_done("s3_done", 32'd3);
        repeat (10) @(posedge clk);
        #2;
        chk_eq("s3_cmd_cnt", 64'(cmd_cnt - b_cmd), 64'd1);
        chk_eq("s3_beats", 64'(dma_beats - b_beats), 64'd20);
        chk_eq("s3_last_at", 64'(last_at - b_beats), 64'd20);
        chk_eq("s3_last", 64'(last_cnt - b_last), 64'd1);
        chk_eq("s3_status_beats", 64'(status[2]), 64'd20);
        chk_eq("s3_idle", 64'(status[3]), 64'd0);
        chk_eq("s3_order", 64'(order_err), 64'd0);

        // Reset after 10 beats of a 40-beat transfer.
        b_beats = dma_beats; b_last = last_cnt;
        rx_limit = rx_sent + 10;
        arm_xfer(64'h4000, 32'd2560);
        wait_beats("s4_ten", b_beats + 10);
        repeat (3) @(posedge clk);
        #2;
        chk_eq("s4_in_data", 64'(status[3]), 64'd2);
        chk_eq("s4_beats_pre", 64'(status[2]), 64'd10);
        @(posedge clk); #1;
        rstn = 1'b0; ctrl[3][0] = 1'b0;
        @(posedge clk); #2;
        chk_eq("s4_rst_state", 64'(status[3]), 64'd0);
        chk_eq("s4_rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk_eq("s4_rst_dma_valid", 64'(dma_tvalid), 64'd0);
        chk_eq("s4_rst_txm_valid", 64'(txm_tvalid), 64'd0);
        chk_eq("s4_rst_txd_valid", 64'(txd_tvalid), 64'd0);
        chk_eq("s4_rst_beats", 64'(status[2]), 64'd0);
        chk_eq("s4_rst_done", 64'(status[1]), 64'd0);
        chk_eq("s4_rst_lat", 64'(status[0]), 64'd0);
        chk_eq("s4_no_last", 64'(last_cnt - b_last), 64'd0);
        #1; rstn = 1'b1;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
